ifetch: RTL and testbench
=========================

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_ADDR, default 32'h00000000: value of o_id_pc while no entry is buffered after reset.
REQ-002 Parameter DEPTH, default 2: combined limit on outstanding memory reads plus buffered entries. Legal values are 2..4.
REQ-003 i_clk  in  1  global clock; all state updates on rising edge.
REQ-004 i_rst  in  1  reset; asynchronous, active-high.
REQ-005 i_pc  in  32  current fetch address from the program counter.
REQ-006 i_halt  in  1  processor halt; blocks new issues.
REQ-007 i_flush  in  1  redirect; discards every fetched or in-flight instruction.
REQ-008 o_pc_adv  out  1  PC may advance this cycle; the PC stage treats ~o_pc_adv as hold.
REQ-009 o_imem_ren  out  1  read request to instruction memory.
REQ-010 o_imem_raddr  out  32  read address, equal to i_pc.
REQ-011 i_imem_rvalid  in  1  read data valid. Responses are in order, arriving 1 or more cycles after the request.
REQ-012 i_imem_rdata  in  32  instruction word.
REQ-013 o_id_valid  out  1  head entry is valid for decode.
REQ-014 o_id_inst  out  32  head instruction.
REQ-015 o_id_pc  out  32  address of the head instruction.
REQ-016 i_id_ready  in  1  decode accepts the head entry this cycle.
REQ-017 o_err  out  1  sticky protocol error flag.

Function
REQ-018 issue = ~i_halt & ~i_flush & (outstanding + count < DEPTH). o_imem_ren and o_pc_adv both equal issue, combinationally.
REQ-019 On issue, i_pc is pushed into an in-order tag FIFO of depth DEPTH, and outstanding increments.
REQ-020 Each accepted response pops the tag FIFO, decrements outstanding, and pushes {tag, i_imem_rdata} into the entry FIFO. The credit rule guarantees this push never overflows.
REQ-021 Issue and response in the same cycle leave outstanding unchanged.
REQ-022 Response latency is 1 cycle minimum: data returned in cycle N is visible on o_id_* in cycle N+1. The block has no combinational path from i_imem_* to o_id_*.
REQ-023 o_id_valid = (count != 0); o_id_inst and o_id_pc show the FIFO head.
REQ-024 Pop occurs when o_id_valid & i_id_ready. Push and pop in the same cycle leave count unchanged.
REQ-025 o_id_* hold their values while o_id_valid & ~i_id_ready.
REQ-026 When count = 0, o_id_inst = 32'h00000013 (NOP) and o_id_pc holds the last popped pc, or RESET_ADDR if nothing has been popped.
REQ-027 Flush, same edge:
  - count <- 0.
  - Tag FIFO is cleared.
  - discard <- outstanding - (i_imem_rvalid ? 1 : 0).
  - A response arriving in the flush cycle is dropped.
  - Any pop is ignored.
REQ-028 While discard > 0, each response is dropped and decrements both discard and outstanding. No entry is pushed.
REQ-029 Issue may resume in the cycle after a flush while discard > 0, still subject to the credit rule of REQ-018. Dropped responses always precede new ones.
REQ-030 Halt blocks issue only. Responses already in flight are still accepted, and decode continues to drain the entry FIFO.
REQ-031 Flush with i_halt high clears state as in REQ-027.
REQ-032 i_imem_rvalid while outstanding = 0 sets o_err and the response is ignored. o_err clears only on reset.
REQ-033 All counters saturate at their legal range, and FIFO pointers wrap modulo DEPTH.

Reset
REQ-034 Asserting i_rst immediately clears count, outstanding, discard, FIFO pointers and o_err, independent of the clock.
REQ-035 While i_rst is high: o_id_valid = 0, o_id_inst = 32'h00000013, o_id_pc = RESET_ADDR, o_imem_ren = 0, o_pc_adv = 0.
REQ-036 Reset mid-operation abandons in-flight reads. The memory model must also be reset so that no stale response arrives.

Verification
REQ-037 Streaming, 1-cycle memory, i_id_ready = 1, i_pc = 0, 4, 8 -> o_id_valid from cycle 2; o_id_pc = 0, 4, 8 in consecutive cycles; o_pc_adv stays 1.
REQ-038 i_id_ready = 0 for 5 cycles -> count reaches 2, o_pc_adv = 0, o_id_pc stays 0 until ready rises.
REQ-039 2-cycle memory, 2 outstanding, flush with no response that cycle -> discard = 2; the next two responses are dropped; the first entry after the flush carries the post-flush i_pc (e.g. 0x100).
REQ-040 Flush in the same cycle as a response and a pop -> response dropped, o_id_valid = 0 next cycle, no o_err.
REQ-041 i_halt = 1 with 1 outstanding -> o_imem_ren = 0; the pending response is still delivered to o_id_*.
REQ-042 Spurious i_imem_rvalid after reset -> o_err = 1 and stays 1; o_id_valid = 0. Then assert i_rst mid-stream -> all outputs return to their reset values with no clock edge.

Source files
------------

// File: rtl/ifetch_if.sv
// Instruction-memory and decode-side bundle of the fetch unit.
// The fetch unit drives through master; memory and decode use slave.
interface ifetch_if;
  logic        o_imem_ren;
  logic [31:0] o_imem_raddr;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        o_id_valid;
  logic [31:0] o_id_inst;
  logic [31:0] o_id_pc;
  logic        i_id_ready;

  modport master (
    output o_imem_ren,
    output o_imem_raddr,
    input  i_imem_rvalid,
    input  i_imem_rdata,
    output o_id_valid,
    output o_id_inst,
    output o_id_pc,
    input  i_id_ready
  );

  modport slave (
    input  o_imem_ren,
    input  o_imem_raddr,
    output i_imem_rvalid,
    input  o_id_valid,
    input  o_id_inst,
    input  o_id_pc,
    output i_imem_rdata,
    output i_id_ready
  );
endinterface

// File: rtl/ifetch.sv
// Credit-limited instruction fetch: in-order tag FIFO for reads in
// flight, entry FIFO toward decode, flush with response discard.
module ifetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          DEPTH      = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_pc,
  input  logic        i_halt,
  input  logic        i_flush,
  output logic        o_pc_adv,
  output logic        o_err,
  ifetch_if.master    bus
);

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [2:0]  DEP  = 3'(DEPTH);
  localparam logic [1:0]  LAST = 2'(DEPTH - 1);

  logic [2:0]  outst;
  logic [2:0]  cnt;
  logic [2:0]  disc;
  logic [1:0]  t_rd;
  logic [1:0]  t_wr;
  logic [1:0]  e_rd;
  logic [1:0]  e_wr;
  logic [31:0] last_pc;
  logic        err;

  logic [31:0] tag_q  [4];
  logic [31:0] inst_q [4];
  logic [31:0] pc_q   [4];

  logic has;
  logic issue;
  logic resp;
  logic drop;
  logic acc;
  logic pop;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == LAST) ? 2'd0 : p + 2'd1;
  endfunction

  assign has   = (cnt != 3'd0);
  assign issue = ~i_halt & ~i_flush & ((outst + cnt) < DEP);
  assign resp  = bus.i_imem_rvalid & (outst != 3'd0);
  assign drop  = resp & (disc != 3'd0);
  assign acc   = resp & (disc == 3'd0) & ~i_flush;
  assign pop   = has & bus.i_id_ready & ~i_flush;

  // reset gates the request outputs without feeding flop inputs
  assign bus.o_imem_ren   = issue & ~i_rst;
  assign o_pc_adv         = issue & ~i_rst;
  assign bus.o_imem_raddr = i_pc;
  assign bus.o_id_valid   = has;
  assign bus.o_id_inst    = has ? inst_q[e_rd] : NOP;
  assign bus.o_id_pc      = has ? pc_q[e_rd] : last_pc;
  assign o_err            = err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      outst   <= 3'd0;
      cnt     <= 3'd0;
      disc    <= 3'd0;
      t_rd    <= 2'd0;
      t_wr    <= 2'd0;
      e_rd    <= 2'd0;
      e_wr    <= 2'd0;
      last_pc <= RESET_ADDR;
      err     <= 1'b0;
    end else begin
      if (bus.i_imem_rvalid && outst == 3'd0)
        err <= 1'b1;
      if (i_flush) begin
        // reads still in flight after this edge must all be dropped
        cnt   <= 3'd0;
        t_rd  <= 2'd0;
        t_wr  <= 2'd0;
        e_rd  <= 2'd0;
        e_wr  <= 2'd0;
        outst <= outst - {2'b0, resp};
        disc  <= outst - {2'b0, resp};
      end else begin
        if (issue)
          t_wr <= nxt(t_wr);
        if (acc) begin
          t_rd <= nxt(t_rd);
          e_wr <= nxt(e_wr);
        end
        if (pop) begin
          e_rd    <= nxt(e_rd);
          last_pc <= pc_q[e_rd];
        end
        if (drop)
          disc <= disc - 3'd1;
        case ({issue, resp})
          2'b10: if (outst != DEP) outst <= outst + 3'd1;
          2'b01: outst <= outst - 3'd1;
          default: ;
        endcase
        case ({acc, pop})
          2'b10: if (cnt != DEP) cnt <= cnt + 3'd1;
          2'b01: cnt <= cnt - 3'd1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (issue)
      tag_q[t_wr] <= i_pc;
    if (acc) begin
      inst_q[e_wr] <= bus.i_imem_rdata;
      pc_q[e_wr]   <= tag_q[t_rd];
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: per-cycle vector table plus an issue-order
// scoreboard checked whenever decode takes an entry.
module tb_ifetch;

  localparam logic [31:0] R   = 32'h0000_0080;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    bit          rb;
    int          lat;
    bit          h;
    bit          f;
    bit          r;
    bit          s;
    logic [31:0] tgt;
    bit          ren;
    bit          val;
    logic [31:0] ipc;
    bit          err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc;
  logic        halt;
  logic        flush;
  logic        pc_adv;
  logic        err;
  logic        spur;
  int          lat;
  int          vectors = 0;
  int          miscompares = 0;

  logic        mv [1:3];
  logic [31:0] ma [1:3];
  logic [31:0] sbq [$];
  vec_t        tv [$];

  always #5 clk = ~clk;

  ifetch_if bus ();

  ifetch #(.RESET_ADDR(R), .DEPTH(3)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_pc(pc),
    .i_halt(halt),
    .i_flush(flush),
    .o_pc_adv(pc_adv),
    .o_err(err),
    .bus(bus)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // fixed-latency in-order memory, cleared by reset
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= 3; k++) begin
        mv[k] <= 1'b0;
        ma[k] <= 32'h0;
      end
    end else begin
      mv[1] <= bus.o_imem_ren;
      ma[1] <= bus.o_imem_raddr;
      for (int k = 2; k <= 3; k++) begin
        mv[k] <= mv[k-1];
        ma[k] <= ma[k-1];
      end
    end
  end

  assign bus.i_imem_rvalid = mv[lat] | spur;
  assign bus.i_imem_rdata  = memf(ma[lat]);

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic chk1(input string n, input logic a, input logic e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", n, a, e);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    if (rst || flush) begin
      sbq.delete();
    end else begin
      if (bus.o_id_valid && bus.i_id_ready) begin
        chk1("sb_nonempty", sbq.size() != 0, 1'b1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("sb_pc", bus.o_id_pc, e);
          chk("sb_inst", bus.o_id_inst, memf(e));
        end
      end
      if (bus.o_imem_ren)
        sbq.push_back(pc);
    end
  end

  function automatic void add(bit rb, int l, bit h, bit f, bit r,
                              bit s, logic [31:0] tgt, bit ren,
                              bit val, logic [31:0] ipc, bit er);
    tv.push_back('{rb, l, h, f, r, s, tgt, ren, val, ipc, er});
  endfunction

  task automatic rst_chk(input string p);
    chk1({p, "_ren"}, bus.o_imem_ren, 1'b0);
    chk1({p, "_adv"}, pc_adv, 1'b0);
    chk1({p, "_valid"}, bus.o_id_valid, 1'b0);
    chk({p, "_inst"}, bus.o_id_inst, NOP);
    chk({p, "_pc"}, bus.o_id_pc, R);
    chk1({p, "_err"}, err, 1'b0);
  endtask

  task automatic do_reset(input int l);
    rst = 1'b1;
    halt = 1'b0;
    flush = 1'b0;
    spur = 1'b0;
    bus.i_id_ready = 1'b0;
    lat = l;
    pc = 32'h0;
    sbq.delete();
    #1;
    rst_chk("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    vec_t v;
    logic a;
    logic fl;
    halt = 1'b0;
    flush = 1'b0;
    spur = 1'b0;
    pc = 32'h0;
    lat = 1;
    bus.i_id_ready = 1'b0;

    // streaming, then decode stall of five cycles
    add(1,1, 0,0,1,0, 0, 1,0,R,0);
    add(0,1, 0,0,1,0, 0, 1,0,R,0);
    add(0,1, 0,0,1,0, 0, 1,1,32'h0,0);
    add(0,1, 0,0,1,0, 0, 1,1,32'h4,0);
    add(0,1, 0,0,1,0, 0, 1,1,32'h8,0);
    add(0,1, 0,0,0,0, 0, 1,1,32'hC,0);
    add(0,1, 0,0,0,0, 0, 0,1,32'hC,0);
    add(0,1, 0,0,0,0, 0, 0,1,32'hC,0);
    add(0,1, 0,0,0,0, 0, 0,1,32'hC,0);
    add(0,1, 0,0,0,0, 0, 0,1,32'hC,0);
    add(0,1, 0,0,1,0, 0, 0,1,32'hC,0);
    add(0,1, 0,0,1,0, 0, 1,1,32'h10,0);
    add(0,1, 0,0,1,0, 0, 1,1,32'h14,0);
    add(0,1, 0,0,1,0, 0, 1,1,32'h18,0);
    // flush with two reads in flight and no response that cycle
    add(1,3, 0,0,1,0, 0, 1,0,R,0);
    add(0,3, 0,0,1,0, 0, 1,0,R,0);
    add(0,3, 0,1,1,0, 32'h100, 0,0,R,0);
    add(0,3, 0,0,1,0, 0, 1,0,R,0);
    add(0,3, 0,0,1,0, 0, 1,0,R,0);
    add(0,3, 0,0,1,0, 0, 1,0,R,0);
    add(0,3, 0,0,1,0, 0, 0,0,R,0);
    add(0,3, 0,0,1,0, 0, 0,1,32'h100,0);
    add(0,3, 0,0,1,0, 0, 1,1,32'h104,0);
    add(0,3, 0,0,1,0, 0, 1,1,32'h108,0);
    add(0,3, 0,0,1,0, 0, 1,0,32'h108,0);
    // flush together with a response and a pop
    add(1,1, 0,0,1,0, 0, 1,0,R,0);
    add(0,1, 0,0,1,0, 0, 1,0,R,0);
    add(0,1, 0,1,1,0, 32'h200, 0,1,32'h0,0);
    add(0,1, 0,0,1,0, 0, 1,0,R,0);
    add(0,1, 0,0,1,0, 0, 1,0,R,0);
    add(0,1, 0,0,1,0, 0, 1,1,32'h200,0);
    // halt with one read outstanding
    add(1,2, 0,0,1,0, 0, 1,0,R,0);
    add(0,2, 1,0,1,0, 0, 0,0,R,0);
    add(0,2, 1,0,1,0, 0, 0,0,R,0);
    add(0,2, 1,0,0,0, 0, 0,1,32'h0,0);
    add(0,2, 1,0,0,0, 0, 0,1,32'h0,0);
    add(0,2, 0,0,1,0, 0, 1,1,32'h0,0);
    add(0,2, 0,0,1,0, 0, 1,0,32'h0,0);
    // spurious response sets the sticky error
    add(1,1, 1,0,0,1, 0, 0,0,R,0);
    add(0,1, 1,0,0,0, 0, 0,0,R,1);
    add(0,1, 0,0,1,0, 0, 1,0,R,1);
    add(0,1, 0,0,1,0, 0, 1,0,R,1);
    add(0,1, 0,0,1,0, 0, 1,1,32'h0,1);

    #2;
    foreach (tv[i]) begin
      v = tv[i];
      if (v.rb)
        do_reset(v.lat);
      halt = v.h;
      flush = v.f;
      bus.i_id_ready = v.r;
      spur = v.s;
      @(negedge clk);
      chk1($sformatf("ren[%0d]", i), bus.o_imem_ren, v.ren);
      chk1($sformatf("adv[%0d]", i), pc_adv, v.ren);
      chk($sformatf("raddr[%0d]", i), bus.o_imem_raddr, pc);
      chk1($sformatf("valid[%0d]", i), bus.o_id_valid, v.val);
      chk($sformatf("id_pc[%0d]", i), bus.o_id_pc, v.ipc);
      chk1($sformatf("err[%0d]", i), err, v.err);
      if (!v.val)
        chk($sformatf("nop[%0d]", i), bus.o_id_inst, NOP);
      a = pc_adv;
      fl = flush;
      @(posedge clk);
      #1;
      spur = 1'b0;
      if (fl)
        pc = v.tgt;
      else if (a)
        pc = pc + 32'd4;
    end

    // reset between edges while the stream is running
    halt = 1'b0;
    bus.i_id_ready = 1'b1;
    @(negedge clk);
    #2;
    rst = 1'b1;
    sbq.delete();
    #1;
    rst_chk("async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    pc = 32'h0;
    @(negedge clk);
    chk1("post_ren", bus.o_imem_ren, 1'b1);
    chk1("post_valid0", bus.o_id_valid, 1'b0);
    chk1("post_err", err, 1'b0);
    @(posedge clk);
    #1;
    halt = 1'b1;
    pc = 32'h4;
    @(negedge clk);
    chk1("post_valid1", bus.o_id_valid, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk1("post_valid2", bus.o_id_valid, 1'b1);
    chk("post_pc", bus.o_id_pc, 32'h0);
    chk1("post_err2", err, 1'b0);
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
